// File: rtl/processor_arm.sv
// processor_arm: single-cycle 64-bit LEGv8 subset processor.
//
// One instruction completes per CLOCK_50 cycle. The block holds the PC, a
// fixed instruction ROM, a 32xN register file, the main decoder, the ALU and
// a DMEM_WORDS x N data memory.
//
// Ports:
//   CLOCK_50        in   system clock, all state updates on the rising edge
//   reset           in   synchronous, active-high; PC<=0, Xi<=i
//   DM_writeData    out  N  value presented to data memory (second read port)
//   DM_addr         out  N  data-memory byte address (ALU result)
//   DM_writeEnable  out  1  store strobe for the current instruction
//   dump            in   simulation aid: prints all data-memory words at each
//                        rising edge while high
//
// Handshake: none. Outputs are combinational functions of the current
// instruction and register state; they are meaningful for the whole cycle and
// are committed at the next rising edge when DM_writeEnable is high.
//
// Supported: ADD, SUB, AND, ORR, LDUR, STUR, CBZ, B. Every other encoding,
// including all-zero words, executes as a NOP.
module processor_arm #(
  parameter int N          = 64,
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  output logic [N-1:0] DM_writeData,
  output logic [N-1:0] DM_addr,
  output logic         DM_writeEnable,
  input  logic         dump
);

  localparam int DA_W = $clog2(DMEM_WORDS);

  typedef logic [DMEM_WORDS-1:0][N-1:0] dmem_t;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_ORR  = 3'd3,
    ALU_PASS = 3'd4
  } alu_op_t;

  // Program image. Words not listed read as 0 and execute as NOP.
  function automatic logic [31:0] rom_word(input logic [5:0] a);
    case (a)
      6'd0:    rom_word = 32'h8B02_0029; // ADD  X9,  X1, X2
      6'd1:    rom_word = 32'hCB01_012A; // SUB  X10, X9, X1
      6'd2:    rom_word = 32'h8A05_006B; // AND  X11, X3, X5
      6'd3:    rom_word = 32'hAA08_008C; // ORR  X12, X4, X8
      6'd4:    rom_word = 32'hF801_0009; // STUR X9,  [X0,#16]
      6'd5:    rom_word = 32'hF841_000D; // LDUR X13, [X0,#16]
      6'd6:    rom_word = 32'hF801_800D; // STUR X13, [X0,#24]
      6'd7:    rom_word = 32'hF802_000A; // STUR X10, [X0,#32]
      6'd8:    rom_word = 32'hF802_800B; // STUR X11, [X0,#40]
      6'd9:    rom_word = 32'hF803_000C; // STUR X12, [X0,#48]
      6'd10:   rom_word = 32'hF845_000E; // LDUR X14, [X0,#80]
      6'd11:   rom_word = 32'hF805_800E; // STUR X14, [X0,#88]
      6'd12:   rom_word = 32'hB400_005F; // CBZ  X31, +2 (taken)
      6'd13:   rom_word = 32'hF803_8009; // STUR X9,  [X0,#56] (skipped)
      6'd14:   rom_word = 32'hB400_0041; // CBZ  X1,  +2 (not taken)
      6'd15:   rom_word = 32'h0000_0000; // NOP
      6'd16:   rom_word = 32'h8B01_003F; // ADD  X31, X1, X1 (discarded)
      6'd17:   rom_word = 32'hF804_001F; // STUR X31, [X0,#64]
      6'd18:   rom_word = 32'h17FF_FFFF; // B    -1
      default: rom_word = 32'h0000_0000;
    endcase
  endfunction

  function automatic dmem_t dmem_init();
    dmem_t d;
    for (int i = 0; i < DMEM_WORDS; i++) d[i] = N'(i);
    return d;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [N-1:0] pc;
  logic [N-1:0] rf [0:31];
  // Loaded once at time 0 (mem[i]=i); reset deliberately leaves it alone.
  dmem_t        dmem = dmem_init();

  // ---------------------------------------------------------------------------
  // Fetch and decode
  // ---------------------------------------------------------------------------
  logic [31:0] inst;
  logic [10:0] op11;
  logic        is_add, is_sub, is_and, is_orr, is_ldur, is_stur, is_cbz, is_b;
  logic [4:0]  rn_addr, rm_addr, rt_addr, rd2_addr;

  assign inst = (int'(pc[7:2]) < IMEM_WORDS) ? rom_word(pc[7:2]) : 32'h0;
  assign op11 = inst[31:21];

  assign is_add  = (op11 == 11'b10001011000);
  assign is_sub  = (op11 == 11'b11001011000);
  assign is_and  = (op11 == 11'b10001010000);
  assign is_orr  = (op11 == 11'b10101010000);
  assign is_ldur = (op11 == 11'b11111000010);
  assign is_stur = (op11 == 11'b11111000000);
  assign is_cbz  = (inst[31:24] == 8'b10110100);
  assign is_b    = (inst[31:26] == 6'b000101);

  assign rt_addr  = inst[4:0];
  assign rn_addr  = inst[9:5];
  assign rm_addr  = inst[20:16];
  // STUR and CBZ need Rt on the second port; R-type needs Rm.
  assign rd2_addr = (is_stur || is_cbz) ? rt_addr : rm_addr;

  logic [N-1:0] rd1, rd2;
  assign rd1 = (rn_addr  == 5'd31) ? '0 : rf[rn_addr];
  assign rd2 = (rd2_addr == 5'd31) ? '0 : rf[rd2_addr];

  logic [N-1:0] imm_d, imm_cb, imm_b;
  assign imm_d  = {{(N-9){inst[20]}}, inst[20:12]};
  assign imm_cb = {{(N-21){inst[23]}}, inst[23:5], 2'b00};
  assign imm_b  = {{(N-28){inst[25]}}, inst[25:0], 2'b00};

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  alu_op_t      alu_op;
  logic [N-1:0] alu_b, alu_result;
  logic         alu_zero;

  always_comb begin
    alu_op = ALU_ADD;
    if (is_sub)      alu_op = ALU_SUB;
    else if (is_and) alu_op = ALU_AND;
    else if (is_orr) alu_op = ALU_ORR;
    else if (is_cbz) alu_op = ALU_PASS;
  end

  assign alu_b = (is_ldur || is_stur) ? imm_d : rd2;

  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_ADD:  alu_result = rd1 + alu_b;
      ALU_SUB:  alu_result = rd1 - alu_b;
      ALU_AND:  alu_result = rd1 & alu_b;
      ALU_ORR:  alu_result = rd1 | alu_b;
      ALU_PASS: alu_result = alu_b;
      default:  alu_result = '0;
    endcase
  end

  assign alu_zero = (alu_result == '0);

  // ---------------------------------------------------------------------------
  // Data memory port and writeback
  // ---------------------------------------------------------------------------
  logic [DA_W-1:0] dm_index;
  logic [N-1:0]    dm_rdata, wb_data;
  logic            reg_write;

  assign dm_index       = alu_result[DA_W+2:3];
  assign dm_rdata       = dmem[dm_index];
  assign DM_addr        = alu_result;
  assign DM_writeData   = rd2;
  assign DM_writeEnable = is_stur && !reset;

  assign reg_write = is_add || is_sub || is_and || is_orr || is_ldur;
  assign wb_data   = is_ldur ? dm_rdata : alu_result;

  // ---------------------------------------------------------------------------
  // Next PC
  // ---------------------------------------------------------------------------
  logic         br_taken;
  logic [N-1:0] br_target;

  assign br_taken  = is_b || (is_cbz && alu_zero);
  assign br_target = pc + (is_b ? imm_b : imm_cb);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      pc <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= N'(i);
    end else begin
      pc <= br_taken ? br_target : pc + N'(4);
      if (reg_write && rt_addr != 5'd31) rf[rt_addr] <= wb_data;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (DM_writeEnable) dmem[dm_index] <= DM_writeData;
  end

`ifndef SYNTHESIS
  always @(posedge CLOCK_50) begin
    if (dump) begin
      for (int i = 0; i < DMEM_WORDS; i++) $display("dmem[%0d] = %0d", i, dmem[i]);
    end
  end
`endif

endmodule

// File: tb/tb_processor_arm.sv
module tb_processor_arm;

  localparam int N = 64;

  logic         CLOCK_50;
  logic         reset;
  logic         dump;
  logic [N-1:0] DM_writeData;
  logic [N-1:0] DM_addr;
  logic         DM_writeEnable;

  int checks;
  int errors;
  int cyc;

  processor_arm #(.N(N), .IMEM_WORDS(64), .DMEM_WORDS(64)) dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .DM_writeData  (DM_writeData),
    .DM_addr       (DM_addr),
    .DM_writeEnable(DM_writeEnable),
    .dump          (dump)
  );

  // Clock / reset
  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Expected per-cycle outputs for the program from PC=0, hand-derived from
  // the reset register values Xi=i and initial memory mem[i]=i.
  localparam int SEQ_LEN = 18;
  logic         exp_we   [SEQ_LEN] = '{0, 0, 0, 0, 1, 0, 1, 1, 1, 1, 0, 1, 0, 0, 0, 0, 1, 0};
  logic [N-1:0] exp_addr [SEQ_LEN] = '{3, 2, 1, 12, 16, 16, 24, 32, 40, 48, 80, 88, 0, 1, 0, 2, 64, 0};
  logic [N-1:0] exp_data [SEQ_LEN] = '{2, 1, 5, 8, 3, 0, 3, 2, 1, 12, 0, 10, 0, 1, 0, 1, 0, 0};
  logic         chk_addr [SEQ_LEN] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 0};
  logic         chk_data [SEQ_LEN] = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 0};

  task automatic test_reset();
    reset = 1'b1;
    dump  = 1'b0;
    repeat (2) begin
      @(posedge CLOCK_50); #1;
      checks++;
      if (DM_writeEnable !== 1'b0) begin
        errors++;
        $display("FAIL reset_we got=%0b exp=0", DM_writeEnable);
      end
      checks++;
      if (DM_addr !== 64'd3) begin
        errors++;
        $display("FAIL reset_addr got=%0d exp=3", DM_addr);
      end
      checks++;
      if (DM_writeData !== 64'd2) begin
        errors++;
        $display("FAIL reset_data got=%0d exp=2", DM_writeData);
      end
    end
  endtask

  // Entered at posedge+1 with reset just released: the current instruction
  // is the word at address 0 and has not executed yet.
  task automatic test_program(input string tag);
    cyc = 0;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (i != 0) begin
        @(posedge CLOCK_50); #1;
        cyc++;
      end
      checks++;
      if (DM_writeEnable !== exp_we[i]) begin
        errors++;
        $display("FAIL %s_we cyc=%0d got=%0b exp=%0b", tag, i, DM_writeEnable, exp_we[i]);
      end
      if (chk_addr[i]) begin
        checks++;
        if (DM_addr !== exp_addr[i]) begin
          errors++;
          $display("FAIL %s_addr cyc=%0d got=%0d exp=%0d", tag, i, DM_addr, exp_addr[i]);
        end
      end
      if (chk_data[i]) begin
        checks++;
        if (DM_writeData !== exp_data[i]) begin
          errors++;
          $display("FAIL %s_data cyc=%0d got=%0d exp=%0d", tag, i, DM_writeData, exp_data[i]);
        end
      end
    end
  endtask

  // The tail of the program is STUR X31,[X0,#64] / B -1 forever: even cycles
  // from 16 on store 0 to address 64, odd cycles are the branch.
  task automatic test_back_to_back(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLOCK_50); #1;
      cyc++;
      checks++;
      if (DM_writeEnable !== ((cyc % 2) == 0)) begin
        errors++;
        $display("FAIL loop_we cyc=%0d got=%0b exp=%0b", cyc, DM_writeEnable, (cyc % 2) == 0);
      end
      if ((cyc % 2) == 0) begin
        checks++;
        if (DM_addr !== 64'd64 || DM_writeData !== 64'd0) begin
          errors++;
          $display("FAIL loop_store cyc=%0d got_addr=%0d got_data=%0d exp_addr=64 exp_data=0",
                   cyc, DM_addr, DM_writeData);
        end
      end
    end
  endtask

  task automatic test_dump();
    dump = 1'b1;
    test_back_to_back(1);
    dump = 1'b0;
    test_back_to_back(4);
  endtask

  task automatic test_reset_mid();
    // Move to a store cycle, then raise reset inside it.
    if ((cyc % 2) != 0) test_back_to_back(1);
    reset = 1'b1;
    #1;
    checks++;
    if (DM_writeEnable !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_we got=%0b exp=0", DM_writeEnable);
    end
    @(posedge CLOCK_50); #1;
    checks++;
    if (DM_writeEnable !== 1'b0 || DM_addr !== 64'd3 || DM_writeData !== 64'd2) begin
      errors++;
      $display("FAIL mid_reset_restart got_we=%0b got_addr=%0d got_data=%0d exp_we=0 exp_addr=3 exp_data=2",
               DM_writeEnable, DM_addr, DM_writeData);
    end
    reset = 1'b0;
    test_program("rerun");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    reset  = 1'b1;
    dump   = 1'b0;
    test_reset();
    reset = 1'b0;
    test_program("prog");
    test_back_to_back(130);
    test_dump();
    test_reset_mid();
    test_back_to_back(6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
